// File: rtl/hwpe_stream_tcdm_fetcher_pkg.sv
// Shared types and constants for the TCDM fetcher: control/flag payloads and FSM encoding.
package hwpe_stream_tcdm_fetcher_pkg;

  localparam int unsigned FETCHER_CNT_WIDTH  = 16;
  localparam int unsigned FETCHER_ADDR_WIDTH = 32;

  // Job descriptor; start is sampled only while the fetcher is idle.
  typedef struct packed {
    logic                          start;
    logic [FETCHER_ADDR_WIDTH-1:0] base_addr;
    logic [FETCHER_CNT_WIDTH-1:0]  n_words;
    logic [FETCHER_CNT_WIDTH-1:0]  stride;
  } ctrl_fetcher_t;

  // Status; done is a single-cycle pulse.
  typedef struct packed {
    logic                         busy;
    logic                         done;
    logic [FETCHER_CNT_WIDTH-1:0] words_left;
  } flags_fetcher_t;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_RUN   = 2'd1,
    FS_DRAIN = 2'd2,
    FS_DONE  = 2'd3
  } fetcher_state_e;

endpackage

// File: rtl/hwpe_stream_tcdm_fetcher_if.sv
// Bus interfaces used by the fetcher.
//   hwpe_stream_intf_tcdm  : TCDM request/response port (master issues reads).
//   hwpe_stream_intf_stream: HWPE-Stream valid/ready channel with data and byte strobes.
interface hwpe_stream_intf_tcdm;
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  logic        r_valid;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, data, strb, input ready);
  modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_tcdm_fetcher_fifo.sv
// Response buffer: power-of-2 FIFO between the TCDM response channel and the output stream.
// Ports: clk_i, rst_ni (async, active-low), clear_i (sync flush),
//        push_i (stream sink), pop_o (stream source; data/strb forced to 0 while empty).
module hwpe_stream_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  hwpe_stream_intf_stream.sink   push_i,
  hwpe_stream_intf_stream.source pop_o
);

  localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned ENTRY_WIDTH = DATA_WIDTH + STRB_WIDTH;
  localparam int unsigned PTR_WIDTH   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_WIDTH   = PTR_WIDTH + 1;

  logic [ENTRY_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [ENTRY_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   empty_c, full_c, push_c, pop_c;

  assign empty_c = (cnt_q == '0);
  assign full_c  = (cnt_q == CNT_WIDTH'(FIFO_DEPTH));
  assign push_c  = push_i.valid & ~full_c;
  assign pop_c   = ~empty_c & pop_o.ready;

  assign push_i.ready = ~full_c;
  assign pop_o.valid  = ~empty_c;
  assign {pop_o.data, pop_o.strb} = empty_c ? '0 : mem_q[rd_ptr_q];

  // Pointer/count update; pointers wrap naturally because the depth is a power of 2.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = {push_i.data, push_i.strb};
      wr_ptr_d        = wr_ptr_q + PTR_WIDTH'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
    end
    unique case ({push_c, pop_c})
      2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
      2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/hwpe_stream_tcdm_fetcher.sv
// Strided TCDM read engine producing an HWPE-Stream of 32-bit words.
// Ports: clk_i, rst_ni (async, active-low), clear_i (sync abort),
//        ctrl_i (start/base_addr/n_words/stride), flags_o (busy/done/words_left),
//        tcdm (read master), pop_o (output stream source).
// Reads are only issued against free buffer slots (credits), so responses are never dropped.
module hwpe_stream_tcdm_fetcher
  import hwpe_stream_tcdm_fetcher_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  ctrl_fetcher_t          ctrl_i,
  output flags_fetcher_t         flags_o,
  hwpe_stream_intf_tcdm.master   tcdm,
  hwpe_stream_intf_stream.source pop_o
);

  localparam int unsigned CRED_WIDTH = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CW         = FETCHER_CNT_WIDTH;
  localparam int unsigned AW         = FETCHER_ADDR_WIDTH;

  fetcher_state_e  state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   stride_q, stride_d;
  logic [CW-1:0]   req_left_q, req_left_d;
  logic [CW-1:0]   words_left_q, words_left_d;
  logic [CRED_WIDTH-1:0] credits_q, credits_d;
  logic            inflight_q, inflight_d;
  logic            start_c, req_c, gnt_hs_c, pop_hs_c, last_pop_c;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DATA_WIDTH)) push_s ();

  assign start_c    = (state_q == FS_IDLE) & ctrl_i.start;
  assign req_c      = (state_q == FS_RUN) & (req_left_q != '0) & (credits_q != '0);
  assign gnt_hs_c   = req_c & tcdm.gnt;
  assign pop_hs_c   = pop_o.valid & pop_o.ready;
  assign last_pop_c = pop_hs_c & (words_left_q == CW'(1));

  assign tcdm.req  = req_c;
  assign tcdm.add  = addr_q;
  assign tcdm.wen  = 1'b1;
  assign tcdm.be   = 4'hF;
  assign tcdm.data = '0;

  // Responses are accepted only for a read issued since the last reset/clear.
  assign push_s.valid = tcdm.r_valid & inflight_q;
  assign push_s.data  = tcdm.r_data;
  assign push_s.strb  = '1;

  hwpe_stream_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) i_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (push_s.sink),
    .pop_o   (pop_o)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      state_q <= FS_IDLE;
    else if (clear_i) state_q <= FS_IDLE;
    else              state_q <= state_d;
  end

  // Next state. Leaving DRAIN on the final pop makes done land the cycle after it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FS_IDLE:  if (ctrl_i.start) state_d = (ctrl_i.n_words == '0) ? FS_DONE : FS_RUN;
      FS_RUN:   if (gnt_hs_c && (req_left_q == CW'(1))) state_d = FS_DRAIN;
      FS_DRAIN: if (last_pop_c) state_d = FS_DONE;
      FS_DONE:  state_d = FS_IDLE;
      default:  state_d = FS_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    flags_o            = '0;
    flags_o.busy       = (state_q == FS_RUN) | (state_q == FS_DRAIN);
    flags_o.done       = (state_q == FS_DONE);
    flags_o.words_left = words_left_q;
  end

  // Address, counters, credits and inflight tracking.
  always_comb begin
    addr_d       = addr_q;
    stride_d     = stride_q;
    req_left_d   = req_left_q;
    words_left_d = words_left_q;
    credits_d    = credits_q;
    inflight_d   = gnt_hs_c | (inflight_q & ~tcdm.r_valid);
    if (start_c) begin
      addr_d       = ctrl_i.base_addr;
      stride_d     = ctrl_i.stride;
      req_left_d   = ctrl_i.n_words;
      words_left_d = ctrl_i.n_words;
    end
    if (gnt_hs_c) begin
      addr_d     = addr_q + AW'(stride_q);
      req_left_d = req_left_q - CW'(1);
    end
    if (pop_hs_c) begin
      words_left_d = words_left_q - CW'(1);
    end
    unique case ({gnt_hs_c, pop_hs_c})
      2'b10:   credits_d = credits_q - CRED_WIDTH'(1);
      2'b01:   credits_d = credits_q + CRED_WIDTH'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q       <= '0;
      stride_q     <= '0;
      req_left_q   <= '0;
      words_left_q <= '0;
      credits_q    <= CRED_WIDTH'(FIFO_DEPTH);
      inflight_q   <= 1'b0;
    end else if (clear_i) begin
      addr_q       <= '0;
      stride_q     <= '0;
      req_left_q   <= '0;
      words_left_q <= '0;
      credits_q    <= CRED_WIDTH'(FIFO_DEPTH);
      inflight_q   <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      stride_q     <= stride_d;
      req_left_q   <= req_left_d;
      words_left_q <= words_left_d;
      credits_q    <= credits_d;
      inflight_q   <= inflight_d;
    end
  end

endmodule

// File: tb/tb_hwpe_stream_tcdm_fetcher.sv
// Directed bench for hwpe_stream_tcdm_fetcher with a 1-cycle-latency TCDM memory model.
module tb_hwpe_stream_tcdm_fetcher;
  import hwpe_stream_tcdm_fetcher_pkg::*;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [31:0] base;
    logic [31:0] exp_last;     // address of the final grant
    logic [15:0] stride;
    logic [15:0] n;
    bit          rnd_gnt;
    int          hold;         // ready held low for rel cycles < hold
    int          hold_grants;  // expected grants by end of hold (-1: skip)
    int          done_rel;     // expected cycle of done, start cycle = 0 (-1: skip)
    int          restart_rel;  // cycle to issue an ignored second start (0: none)
  } vec_t;

  logic clk = 1'b0;
  logic rst_ni, clear_i;
  ctrl_fetcher_t  ctrl;
  flags_fetcher_t flags;

  hwpe_stream_intf_tcdm tcdm ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) pop ();

  hwpe_stream_tcdm_fetcher #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .ctrl_i  (ctrl),
    .flags_o (flags),
    .tcdm    (tcdm.master),
    .pop_o   (pop.source)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  bit          pend_v = 1'b0;
  logic [31:0] pend_d = '0;
  int          grants, pops, dones, rel;
  int          first_req_rel, done_rel, last_pop_rel;
  logic [31:0] cur_addr_exp, last_grant_addr, prev_add, prev_pop_data;
  logic [15:0] exp_stride;
  bit          rnd_gnt, prev_stall, prev_pop_stall;
  int          ready_hold;
  bit          start_drv = 1'b0;
  bit          clear_drv = 1'b0;
  vec_t        vecs[6];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (rel %0d)", name, act, exp, rel);
  endtask

  task automatic model_reset();
    exp_q.delete();
    grants = 0; pops = 0; dones = 0; rel = 0;
    first_req_rel = -1; done_rel = -1; last_pop_rel = -1;
    prev_stall = 1'b0; prev_pop_stall = 1'b0;
  endtask

  // One clock: drive inputs after the edge, sample and score on the falling edge.
  task automatic step();
    @(posedge clk); #1;
    tcdm.r_valid = pend_v;
    tcdm.r_data  = pend_v ? pend_d : 32'hDEAD_BEEF;
    ctrl.start   = start_drv; start_drv = 1'b0;
    clear_i      = clear_drv; clear_drv = 1'b0;
    tcdm.gnt     = rnd_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
    pop.ready    = (rel < ready_hold) ? 1'b0 : 1'b1;
    @(negedge clk);
    pend_v = 1'b0;
    if (tcdm.req && first_req_rel < 0) first_req_rel = rel;
    if (prev_stall && tcdm.req) chk("add_hold", tcdm.add, prev_add);
    if (tcdm.req && tcdm.gnt) begin
      chk("addr", tcdm.add, cur_addr_exp);
      chk("rd_attr", {27'd0, tcdm.wen, tcdm.be}, 32'h1F);
      chk("wdata", tcdm.data, 32'h0);
      exp_q.push_back(mem_word(cur_addr_exp));
      pend_v = 1'b1;
      pend_d = mem_word(tcdm.add);
      last_grant_addr = tcdm.add;
      cur_addr_exp = cur_addr_exp + {16'd0, exp_stride};
      grants++;
      chk("credit", 32'((grants - pops) <= int'(DEPTH)), 32'd1);
    end
    prev_stall = tcdm.req & ~tcdm.gnt;
    prev_add   = tcdm.add;
    if (prev_pop_stall && pop.valid) chk("pop_hold", pop.data, prev_pop_data);
    if (pop.valid && pop.ready) begin
      if (exp_q.size() == 0) chk("spurious_pop", pop.data, 32'hFFFF_FFFF);
      else                   chk("pop_data", pop.data, exp_q.pop_front());
      chk("pop_strb", {28'd0, pop.strb}, 32'hF);
      pops++;
      last_pop_rel = rel;
    end
    if (!pop.valid) chk("idle_data", pop.data | {28'd0, pop.strb}, 32'h0);
    prev_pop_stall = pop.valid & ~pop.ready;
    prev_pop_data  = pop.data;
    if (flags.done) begin
      dones++;
      done_rel = rel;
    end
    rel++;
  endtask

  task automatic run_vec(input vec_t v);
    model_reset();
    cur_addr_exp = v.base; exp_stride = v.stride;
    rnd_gnt = v.rnd_gnt; ready_hold = v.hold;
    ctrl.base_addr = v.base; ctrl.stride = v.stride; ctrl.n_words = v.n;
    start_drv = 1'b1;
    step();
    step();
    chk("busy_start", {31'd0, flags.busy}, {31'd0, v.n != 16'd0});
    chk("words_left_start", {16'd0, flags.words_left}, {16'd0, v.n});
    for (int i = 0; i < 400 && dones == 0; i++) begin
      if (v.restart_rel != 0 && rel == v.restart_rel) begin
        ctrl.base_addr = 32'h900;
        start_drv = 1'b1;
      end
      if (v.hold_grants >= 0 && rel == v.hold) begin
        chk("hold_grants", grants, v.hold_grants);
        chk("hold_req", {31'd0, tcdm.req}, 32'd0);
      end
      step();
    end
    chk("done_seen", dones, 1);
    chk("grants", grants, {16'd0, v.n});
    chk("pops", pops, {16'd0, v.n});
    chk("first_req", first_req_rel, (v.n != 16'd0) ? 1 : -1);
    if (v.n != 16'd0) begin
      chk("last_addr", last_grant_addr, v.exp_last);
      chk("done_lat", done_rel, last_pop_rel + 1);
    end
    if (v.done_rel >= 0) chk("done_rel", done_rel, v.done_rel);
    step();
    chk("busy_end", {31'd0, flags.busy}, 32'd0);
    chk("done_pulse", {31'd0, flags.done}, 32'd0);
    chk("words_left_end", {16'd0, flags.words_left}, 32'd0);
    step();
    chk("single_done", dones, 1);
  endtask

  initial begin
    vec_t after;
    rst_ni = 1'b0; clear_i = 1'b0; ctrl = '0;
    tcdm.gnt = 1'b0; tcdm.r_valid = 1'b0; tcdm.r_data = '0; pop.ready = 1'b0;
    model_reset();
    rnd_gnt = 1'b0; ready_hold = 0; exp_stride = '0; cur_addr_exp = '0;
    // base, exp_last, stride, n, rnd_gnt, hold, hold_grants, done_rel, restart_rel
    vecs[0] = '{32'h0000_0100, 32'h0000_011C, 16'd4,    16'd8,  1'b0, 0,  -1, 11, 0};
    vecs[1] = '{32'h0000_1000, 32'h0000_1024, 16'd4,    16'd10, 1'b0, 20,  4, -1, 0};
    vecs[2] = '{32'h0000_2000, 32'h0000_23C0, 16'h40,   16'd16, 1'b1, 0,  -1, -1, 0};
    vecs[3] = '{32'h0000_3000, 32'h0000_0000, 16'd4,    16'd0,  1'b0, 0,  -1,  1, 0};
    vecs[4] = '{32'hFFFF_FFF8, 32'h0000_0000, 16'd8,    16'd2,  1'b0, 0,  -1,  5, 0};
    vecs[5] = '{32'h0000_0400, 32'h0000_041C, 16'd4,    16'd8,  1'b0, 0,  -1, 11, 3};

    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, tcdm.req}, 32'd0);
    chk("rst_add", tcdm.add, 32'd0);
    chk("rst_valid", {31'd0, pop.valid}, 32'd0);
    chk("rst_data", pop.data, 32'd0);
    chk("rst_strb", {28'd0, pop.strb}, 32'd0);
    chk("rst_flags", {13'd0, flags}, 32'd0);
    chk("rst_credits", 32'(dut.credits_q), DEPTH);
    @(posedge clk); #1 rst_ni = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, flags.busy}, 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Abort after three grants of a 12-word fetch.
    model_reset();
    cur_addr_exp = 32'h5000; exp_stride = 16'd4; rnd_gnt = 1'b0; ready_hold = 0;
    ctrl.base_addr = 32'h5000; ctrl.stride = 16'd4; ctrl.n_words = 16'd12;
    start_drv = 1'b1;
    step();
    for (int i = 0; i < 20 && grants < 3; i++) step();
    chk("abort_grants", grants, 3);
    clear_drv = 1'b1;
    step();
    exp_q.delete();
    step();
    chk("abort_req", {31'd0, tcdm.req}, 32'd0);
    chk("abort_valid", {31'd0, pop.valid}, 32'd0);
    chk("abort_words_left", {16'd0, flags.words_left}, 32'd0);
    chk("abort_busy", {31'd0, flags.busy}, 32'd0);
    step();
    chk("abort_discard", {31'd0, pop.valid}, 32'd0);
    repeat (3) step();
    chk("abort_no_done", dones, 0);

    after = '{32'h0000_0600, 32'h0000_060C, 16'd4, 16'd4, 1'b0, 0, -1, 7, 0};
    run_vec(after);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_tcdm_fetcher.md
# hwpe_stream_tcdm_fetcher

Read-side engine that fetches a strided sequence of 32-bit words from a TCDM port and emits them as an HWPE-Stream. It is the producer that sits upstream of a stream sink such as a FIFO, turning a memory region into a stream. Responses land in an internal buffer, and credit accounting guarantees every granted read has a free slot. Backpressure on the output therefore never drops data and never stalls the TCDM response channel.

## Interface
Parameters:
- DATA_WIDTH, 32: stream and TCDM data width; only 32 is supported.
- FIFO_DEPTH, 4: response buffer depth and maximum credits; power of 2, at least 2.

Ports:
- clk_i  in  1: clock.
- rst_ni  in  1: reset, asynchronous, active-low.
- clear_i  in  1: synchronous clear; same effect as reset.
- ctrl_i  in  ctrl_fetcher_t: start (1), base_addr (32), n_words (16), stride (16, byte stride, unsigned).
- flags_o  out  flags_fetcher_t: busy (1), done (1-cycle pulse), words_left (16).
- tcdm  hwpe_stream_intf_tcdm.master: req, gnt, add[31:0], wen, be[3:0], data[31:0], r_data[31:0], r_valid.
- pop_o  hwpe_stream_intf_stream.source: valid, ready, data[31:0], strb[3:0].

## Operation
- FSM states:
  - IDLE: start=1 latches base_addr, n_words and stride. Go to RUN, or to DONE if n_words=0.
  - RUN: issues reads. Go to DRAIN when the last request is granted.
  - DRAIN: waits until inflight=0 and the buffer is empty. Then go to DONE.
  - DONE: asserts flags_o.done for one cycle, then returns to IDLE.
- start in any state other than IDLE is ignored.
- Address generation:
  - addr_q is initialised to base_addr.
  - addr_q += stride on each grant (req & gnt), 32-bit modulo with wrap silently allowed.
  - tcdm.add = addr_q.
- tcdm.wen=1 (read), tcdm.be=4'hF, tcdm.data=0.
- Request condition: tcdm.req = (RUN) & (req_left != 0) & (credits != 0).
  - While req=1 and gnt=0, add stays stable.
  - req may drop only when credits reach 0.
- credits_q, width clog2(FIFO_DEPTH)+1:
  - Reset value is FIFO_DEPTH.
  - Decrement on a grant; increment on a pop handshake (pop_o.valid & pop_o.ready).
  - Both in the same cycle leaves it unchanged. It never underflows or exceeds FIFO_DEPTH.
- inflight_q, 1 bit: set on grant, cleared on r_valid. A grant with r_valid in the same cycle keeps it at 1.
- Response path: r_valid pushes {r_data, 4'hF} into the buffer.
  - The buffer is guaranteed non-full by the credits.
  - An r_valid while the buffer is full is a protocol violation; the bench asserts it never occurs.
- words_left:
  - Loaded with n_words on start.
  - Decrements on each output pop handshake and reaches 0 exactly when the last word is consumed.
- req_left is an internal counter loaded with n_words and decremented on each grant.

## Timing
- Reset/clear values:
  - FSM is IDLE, req=0, add=0.
  - pop_o.valid=0, pop_o.data=0, pop_o.strb=0.
  - busy=0, done=0, words_left=0, credits=FIFO_DEPTH.
- busy=1 in RUN and DRAIN.
- Cycle latencies:
  - The first request is issued the cycle after start is sampled.
  - TCDM response latency is fixed at 1 cycle: r_valid follows the grant by exactly one cycle.
  - pop_o.valid rises the cycle after r_valid, so there are 2 cycles from first grant to first output.
- With gnt held at 1 and ready held at 1, one word is output per cycle. This requires FIFO_DEPTH ≥ 2.
- pop_o follows stream rules:
  - While valid=1 and ready=0, data and strb are held.
  - data and strb are zero whenever valid=0.
- flags_o.done is asserted the cycle after the final pop handshake, or the cycle after start when n_words=0.
- Reset or clear mid-transfer aborts it immediately:
  - Buffer is flushed and the FSM returns to IDLE.
  - Any pending r_valid in the following cycle is discarded.
  - done is not pulsed.

## Structure
- hwpe_stream_package gains:
  - ctrl_fetcher_t and flags_fetcher_t packed structs.
  - A constant FETCHER_CNT_WIDTH = 16.
- One sub-module: hwpe_stream_fifo, used as the response buffer.
  - Parameters: DATA_WIDTH, FIFO_DEPTH.
  - Connected to a local hwpe_stream_intf_stream on the push side and to pop_o on the pop side.
  - Sharing clear_i.
- The top level holds the FSM, the address, credit and inflight registers, and the counters. Target is about 200 lines.

## Test plan
- Basic strided fetch: base=0x100, stride=4, n_words=8, gnt=1, ready=1 → addresses 0x100..0x11C, one word per cycle, r_data order preserved, done 1 cycle after the 8th pop, busy low afterwards.
- Output backpressure: FIFO_DEPTH=4, n_words=10, ready=0 for 20 cycles → exactly 4 grants then req=0. Release ready → remaining 6 words fetched, none lost or duplicated, credits never negative.
- Random grant stall: n_words=16, gnt random at 50% → add is stable while req & !gnt, 16 grants in total, stream data equals memory model contents.
- Zero length and wrap: n_words=0 → no req, done pulse the cycle after start. Then base=0xFFFFFFF8, stride=8, n_words=2 → addresses 0xFFFFFFF8 then 0x0.
- Abort: clear_i asserted after 3 grants of a 12-word fetch → next cycle req=0, pop_o.valid=0, words_left=0, no done pulse. A new start then works correctly.
- Start while busy: a second start with base=0x900 during RUN is ignored, and the original address sequence continues unchanged.
